// File: rtl/inp_outp.sv
// -----------------------------------------------------------------------------
// inp_outp - registered 4-input / 1-output Boolean function cell.
//
// The four control levels a, b, c, d are brought into the clk domain through a
// SYNC_STAGES-deep flop chain. The synchronized index {a,b,c,d} (a is the MSB)
// then selects one bit of TRUTH_TABLE, and that bit is registered onto z. The
// cell also produces one-cycle pulses on z edges and a saturating count of
// z transitions.
//
// Parameters:
//   TRUTH_TABLE  16-bit table; bit i is z for index i = {a,b,c,d}
//   SYNC_STAGES  synchronizer depth per input (0..4; 0 = direct sampling)
//   CNT_W        toggle_count width (1..32)
//
// Ports:
//   clk           system clock, rising-edge active
//   rst_n         asynchronous active-low reset
//   a, b, c, d    function inputs (index bits 3..0)
//   z             registered function result
//   z_rise        one-cycle pulse in the cycle z first reads 1
//   z_fall        one-cycle pulse in the cycle z first reads 0
//   toggle_count  number of z transitions since reset, saturating at all-ones
// -----------------------------------------------------------------------------
module inp_outp #(
   parameter logic [15:0] TRUTH_TABLE = 16'hF888,
   parameter int          SYNC_STAGES = 2,
   parameter int          CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   output logic             z,
   output logic             z_rise,
   output logic             z_fall,
   output logic [CNT_W-1:0] toggle_count
);

   logic [3:0]       idx_s;
   logic             z_next_s;
   logic             changed_s;
   logic             cnt_max_s;

   logic             z_r;
   logic             z_rise_r;
   logic             z_fall_r;
   logic [CNT_W-1:0] toggle_cnt_r;

   generate
      if (SYNC_STAGES == 0) begin : g_no_sync
         // Inputs feed the lookup directly; the z register is the only sampler.
         assign idx_s = {a, b, c, d};
      end else begin : g_sync
         logic [3:0] sync_r [SYNC_STAGES];

         // Synchronizer chain; reset value 0 so index 0 is looked up first.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < SYNC_STAGES; i++) begin
                  sync_r[i] <= 4'b0000;
               end
            end else begin
               sync_r[0] <= {a, b, c, d};
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_r[i] <= sync_r[i-1];
               end
            end
         end

         assign idx_s = sync_r[SYNC_STAGES-1];
      end
   endgenerate

   // Table lookup plus change / saturation detection for the output register.
   always_comb begin
      z_next_s  = TRUTH_TABLE[idx_s];
      changed_s = z_next_s ^ z_r;
      if (toggle_cnt_r == {CNT_W{1'b1}}) begin
         cnt_max_s = 1'b1;
      end else begin
         cnt_max_s = 1'b0;
      end
   end

   // Output register: z, its edge pulses and the transition counter update
   // together, so the pulses and the count line up with the new z value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_r          <= 1'b0;
         z_rise_r     <= 1'b0;
         z_fall_r     <= 1'b0;
         toggle_cnt_r <= {CNT_W{1'b0}};
      end else begin
         z_r      <= z_next_s;
         z_rise_r <= z_next_s & ~z_r;
         z_fall_r <= ~z_next_s & z_r;
         if (changed_s && !cnt_max_s) begin
            toggle_cnt_r <= toggle_cnt_r + CNT_W'(1);
         end else begin
            toggle_cnt_r <= toggle_cnt_r;
         end
      end
   end

   assign z            = z_r;
   assign z_rise       = z_rise_r;
   assign z_fall       = z_fall_r;
   assign toggle_count = toggle_cnt_r;

endmodule

// File: tb/tb_inp_outp.sv
// -----------------------------------------------------------------------------
// tb_inp_outp - self-checking bench for inp_outp.
//
// Four instances cover the parameter sets of interest:
//   u0  default table, SYNC_STAGES=2, CNT_W=8   (table sweep, edge pulses)
//   u1  TRUTH_TABLE=16'hA5C3, SYNC_STAGES=0      (exhaustive index walk)
//   u2  default table, CNT_W=3                   (counter saturation)
//   u3  TRUTH_TABLE=16'h0001                     (rise right after reset)
// Expected z values are queued when stimulus is driven and popped when the
// DUT is due to present them.
// -----------------------------------------------------------------------------
module tb_inp_outp;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   logic [3:0] in0, in1, in2, in3;
   logic       z0, r0, f0;
   logic       z1, r1, f1;
   logic       z2, r2, f2;
   logic       z3, r3, f3;
   logic [7:0] c0, c1, c3;
   logic [2:0] c2;

   inp_outp #(.TRUTH_TABLE(16'hF888), .SYNC_STAGES(2), .CNT_W(8)) u0 (
      .clk(clk), .rst_n(rst_n),
      .a(in0[3]), .b(in0[2]), .c(in0[1]), .d(in0[0]),
      .z(z0), .z_rise(r0), .z_fall(f0), .toggle_count(c0));

   inp_outp #(.TRUTH_TABLE(16'hA5C3), .SYNC_STAGES(0), .CNT_W(8)) u1 (
      .clk(clk), .rst_n(rst_n),
      .a(in1[3]), .b(in1[2]), .c(in1[1]), .d(in1[0]),
      .z(z1), .z_rise(r1), .z_fall(f1), .toggle_count(c1));

   inp_outp #(.TRUTH_TABLE(16'hF888), .SYNC_STAGES(2), .CNT_W(3)) u2 (
      .clk(clk), .rst_n(rst_n),
      .a(in2[3]), .b(in2[2]), .c(in2[1]), .d(in2[0]),
      .z(z2), .z_rise(r2), .z_fall(f2), .toggle_count(c2));

   inp_outp #(.TRUTH_TABLE(16'h0001), .SYNC_STAGES(2), .CNT_W(8)) u3 (
      .clk(clk), .rst_n(rst_n),
      .a(in3[3]), .b(in3[2]), .c(in3[1]), .d(in3[0]),
      .z(z3), .z_rise(r3), .z_fall(f3), .toggle_count(c3));

   typedef struct {
      logic [3:0] in;
      logic       z;
   } vec_t;

   vec_t       vecs [11];
   logic       exp_q [$];
   int         checks   = 0;
   int         failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      logic        prev_z;
      logic        e;
      int          exp_cnt;
      logic [15:0] tt1;

      // {abcd} sweep against z = (a & b) | (c & d).
      vecs[0]  = '{4'b0000, 1'b0};
      vecs[1]  = '{4'b0100, 1'b0};
      vecs[2]  = '{4'b1100, 1'b1};
      vecs[3]  = '{4'b1110, 1'b1};
      vecs[4]  = '{4'b1111, 1'b1};
      vecs[5]  = '{4'b0111, 1'b1};
      vecs[6]  = '{4'b0011, 1'b1};
      vecs[7]  = '{4'b0001, 1'b0};
      vecs[8]  = '{4'b1001, 1'b0};
      vecs[9]  = '{4'b1101, 1'b1};
      vecs[10] = '{4'b0101, 1'b0};
      tt1 = 16'hA5C3;

      // ---- Reset: asynchronous assertion, then held with inputs toggling.
      rst_n = 1'b1;
      in0 = 4'b0000; in1 = 4'b0000; in2 = 4'b0000; in3 = 4'b0000;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_z0", {31'd0, z0}, 32'd0);
      chk("rst_async_cnt0", {24'd0, c0}, 32'd0);
      chk("rst_async_z3", {31'd0, z3}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in0 = 4'($urandom); in1 = 4'($urandom); in2 = 4'($urandom); in3 = 4'($urandom);
      end
      @(posedge clk); #1;
      chk("rst_hold_z0", {31'd0, z0}, 32'd0);
      chk("rst_hold_pulses0", {30'd0, r0, f0}, 32'd0);
      chk("rst_hold_cnt0", {24'd0, c0}, 32'd0);
      chk("rst_hold_z1", {31'd0, z1}, 32'd0);
      chk("rst_hold_cnt2", {29'd0, c2}, 32'd0);
      chk("rst_hold_z3", {31'd0, z3}, 32'd0);

      // ---- Release with all inputs 0; u3 (table bit 0 set) rises at once.
      @(negedge clk);
      in0 = 4'b0000; in1 = 4'b0000; in2 = 4'b0000; in3 = 4'b0000;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_z3", {31'd0, z3}, 32'd1);
      chk("post_rst_rise3", {31'd0, r3}, 32'd1);
      chk("post_rst_fall3", {31'd0, f3}, 32'd0);
      chk("post_rst_cnt3", {24'd0, c3}, 32'd1);
      chk("post_rst_z0", {31'd0, z0}, 32'd0);
      @(posedge clk); #1;
      chk("post_rst_rise3_gone", {31'd0, r3}, 32'd0);
      chk("post_rst_z3_hold", {31'd0, z3}, 32'd1);
      chk("post_rst_cnt3_hold", {24'd0, c3}, 32'd1);

      // ---- Default table sweep: z follows exactly 3 edges after a change.
      prev_z  = 1'b0;
      exp_cnt = 0;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         in0 = vecs[i].in;
         exp_q.push_back(vecs[i].z);
         @(posedge clk); #1;
         chk("sweep_edge1_z", {31'd0, z0}, {31'd0, prev_z});
         @(posedge clk); #1;
         chk("sweep_edge2_z", {31'd0, z0}, {31'd0, prev_z});
         @(posedge clk); #1;
         e = exp_q.pop_front();
         chk("sweep_z", {31'd0, z0}, {31'd0, e});
         chk("sweep_rise", {31'd0, r0}, {31'd0, e & ~prev_z});
         chk("sweep_fall", {31'd0, f0}, {31'd0, ~e & prev_z});
         if (e != prev_z) begin
            exp_cnt++;
         end
         chk("sweep_cnt", {24'd0, c0}, 32'(exp_cnt));
         @(posedge clk); #1;
         chk("sweep_pulse_end", {30'd0, r0, f0}, 32'd0);
         prev_z = e;
         repeat (15) @(posedge clk);
      end
      // Four transitions occur in this sequence (0->1, 1->0, 0->1, 1->0).
      chk("sweep_final_cnt", {24'd0, c0}, 32'd4);

      // ---- Exhaustive walk, no synchronizer: one-edge latency.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         in1 = 4'(i);
         exp_q.push_back(tt1[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         chk("walk_z", {31'd0, z1}, {31'd0, e});
      end

      // ---- Saturation: b held high so z = a; toggle a ten times.
      @(negedge clk);
      in2 = 4'b0100;
      repeat (4) @(posedge clk);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         in2[3] = ~in2[3];
         exp_q.push_back(in2[3]);
         repeat (3) @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk("sat_z", {31'd0, z2}, {31'd0, e});
         chk("sat_cnt", {29'd0, c2}, (k < 7) ? 32'(k) : 32'd7);
      end

      // ---- Mid-operation asynchronous reset clears state immediately.
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_cnt0", {24'd0, c0}, 32'd0);
      chk("midrst_z1", {31'd0, z1}, 32'd0);
      chk("midrst_cnt2", {29'd0, c2}, 32'd0);
      chk("midrst_z3", {31'd0, z3}, 32'd0);
      chk("midrst_cnt3", {24'd0, c3}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
